// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALUCon opcode values,
// arbiter state encoding and a helper for index widths.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLLV = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SRLV = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SRAV = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester and response channel bundle of the ALU share arbiter.
// master: requester/consumer side, slave: arbiter side.
interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_alucon;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*5-1:0]      req_shamt;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_result;
  logic                      resp_overflow;

  modport master (
    output req_valid, req_alucon, req_a, req_b, req_shamt, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_overflow
  );

  modport slave (
    input  req_valid, req_alucon, req_a, req_b, req_shamt, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_overflow
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request bit searching
// upward from last+1 with wrap-around. Returns one-hot grant and index.
module alu_share_arbiter_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last) + i) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// Flow per operation: IDLE (grant + latch operands) -> EXEC (operands held
// on the ALU for a full cycle, result captured) -> RESP (result held until
// the consumer takes it). Optional build macro ALU_ARB_PRIO_EN gives
// requester 0 strict priority; the others then rotate among themselves.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  alu_share_arbiter_if.slave bus,
  output logic [OP_W-1:0]    alu_con,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [4:0]         alu_shamt,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_overflow
);

  arb_state_t          state;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     serve_id;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [DATA_W-1:0]   rsp_result;
  logic                rsp_overflow;

  logic [NUM_REQ-1:0]  win_oh;
  logic [ID_W-1:0]     win_idx;
  logic                win_any;

  logic [OP_W-1:0]     sel_con;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [4:0]          sel_shamt;

`ifdef ALU_ARB_PRIO_EN
  // last_grant only ever holds a winner from 1..NUM_REQ-1 in this build, so
  // it is the rotation point of the lower-priority group.
  localparam int SUB_N  = NUM_REQ - 1;
  localparam int SUB_IW = id_width(SUB_N);

  logic [SUB_N-1:0]  sub_grant;
  logic [SUB_IW-1:0] sub_idx;
  logic              sub_found;
  logic [SUB_IW-1:0] sub_last;

  assign sub_last = SUB_IW'(last_grant - ID_W'(1));

  alu_share_arbiter_rr_arbiter #(.N(SUB_N), .IW(SUB_IW)) u_rr (
    .req   (bus.req_valid[NUM_REQ-1:1]),
    .last  (sub_last),
    .grant (sub_grant),
    .idx   (sub_idx),
    .found (sub_found)
  );

  // Requester 0 overrides the rotating group whenever it is pending.
  always_comb begin
    if (bus.req_valid[0]) begin
      win_oh  = NUM_REQ'(1);
      win_idx = '0;
      win_any = 1'b1;
    end else begin
      win_oh  = {sub_grant, 1'b0};
      win_idx = ID_W'(sub_idx) + ID_W'(1);
      win_any = sub_found;
    end
  end
`else
  alu_share_arbiter_rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .req   (bus.req_valid),
    .last  (last_grant),
    .grant (win_oh),
    .idx   (win_idx),
    .found (win_any)
  );
`endif

  // Operand mux: pick the winner's slice out of the flattened request buses.
  always_comb begin
    sel_con   = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_shamt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        sel_con   = bus.req_alucon[i*OP_W +: OP_W];
        sel_a     = bus.req_a[i*DATA_W +: DATA_W];
        sel_b     = bus.req_b[i*DATA_W +: DATA_W];
        sel_shamt = bus.req_shamt[i*5 +: 5];
      end
    end
  end

  // Grant is only offered while idle, and only for the cycle it is accepted.
  assign bus.req_ready     = (state == ST_IDLE) ? win_oh : '0;
  assign bus.resp_valid    = rsp_valid;
  assign bus.resp_id       = rsp_id;
  assign bus.resp_result   = rsp_result;
  assign bus.resp_overflow = rsp_overflow;

  // Control FSM; ALU operand and response registers load from here so they
  // stay frozen whenever no operation is moving through.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      serve_id     <= '0;
      alu_con      <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_shamt    <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            alu_con   <= sel_con;
            alu_a     <= sel_a;
            alu_b     <= sel_b;
            alu_shamt <= sel_shamt;
            serve_id  <= win_idx;
`ifdef ALU_ARB_PRIO_EN
            if (win_idx != '0) last_grant <= win_idx;
`else
            last_grant <= win_idx;
`endif
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result   <= alu_result;
          rsp_overflow <= alu_overflow;
          rsp_id       <= serve_id;
          rsp_valid    <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
